// File: rtl/oldland_bus_pkg.sv
`default_nettype none
// ============================================================================
// oldland_bus_pkg : arbiter state encodings and default parameters
// Revision 1.0
// ============================================================================
package oldland_bus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_BUSY = 2'd1,
        ARB_D_BUSY = 2'd2
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int DEFAULT_MAX_D_GRANTS   = 4;

    localparam logic [3:0] FETCH_BYTESEL = 4'hf;

endpackage
`default_nettype wire

// File: rtl/oldland_bus_timeout.sv
`default_nettype none
// ============================================================================
// oldland_bus_timeout : per-transaction hang detector (load / count / expire)
// Revision 1.0
// ============================================================================
module oldland_bus_timeout
    import oldland_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Count holds busy-cycle index minus one, so expiry lands on busy cycle TIMEOUT_CYCLES.
    assign expire = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/oldland_bus_arbiter.sv
`default_nettype none
// ============================================================================
// oldland_bus_arbiter : fetch / load-store sharing of one memory bus master
// Revision 1.0
// ============================================================================
module oldland_bus_arbiter
    import oldland_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int MAX_D_GRANTS   = DEFAULT_MAX_D_GRANTS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_access,
    input  logic [29:0] i_addr,
    output logic        i_ack,
    output logic        i_error,
    output logic [31:0] i_data,
    input  logic        d_access,
    input  logic [29:0] d_addr,
    input  logic        d_wr_en,
    input  logic [31:0] d_wr_val,
    input  logic [3:0]  d_bytesel,
    output logic        d_ack,
    output logic        d_error,
    output logic [31:0] d_data,
    output logic        m_access,
    output logic [29:0] m_addr,
    output logic        m_wr_en,
    output logic [31:0] m_wr_val,
    output logic [3:0]  m_bytesel,
    input  logic        m_ack,
    input  logic        m_error,
    input  logic [31:0] m_data
);

    localparam int CTR_W = $clog2(MAX_D_GRANTS + 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CTR_W-1:0] d_grant_ctr;
    logic             grant_i;
    logic             grant_d;
    logic             busy;
    logic             expire;
    logic             bus_done;
    logic             resp_ack;
    logic             resp_err;
    logic             i_owner;
    logic             d_owner;

    assign busy     = (state != ARB_IDLE);
    assign bus_done = busy && (m_ack || m_error || expire);
    assign resp_err = m_error || (expire && !m_ack);
    assign resp_ack = m_ack && !m_error;

    // Ownership is masked by rst_n so a response during reset is never forwarded.
    assign i_owner = rst_n && (state == ARB_I_BUSY);
    assign d_owner = rst_n && (state == ARB_D_BUSY);

    oldland_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (grant_i || grant_d),
        .enable(busy),
        .expire(expire)
    );

    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (d_access && !(i_access && (d_grant_ctr == CTR_W'(MAX_D_GRANTS)))) begin
                    grant_d    = 1'b1;
                    state_next = ARB_D_BUSY;
                end else if (i_access) begin
                    grant_i    = 1'b1;
                    state_next = ARB_I_BUSY;
                end
            end
            ARB_I_BUSY, ARB_D_BUSY: begin
                if (bus_done) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            d_grant_ctr <= '0;
            m_access    <= 1'b0;
            m_addr      <= '0;
            m_wr_en     <= 1'b0;
            m_wr_val    <= '0;
            m_bytesel   <= '0;
        end else begin
            state <= state_next;
            if (grant_d) begin
                m_access    <= 1'b1;
                m_addr      <= d_addr;
                m_wr_en     <= d_wr_en;
                m_wr_val    <= d_wr_val;
                m_bytesel   <= d_bytesel;
                d_grant_ctr <= i_access ? d_grant_ctr + CTR_W'(1) : '0;
            end else if (grant_i) begin
                m_access    <= 1'b1;
                m_addr      <= i_addr;
                m_wr_en     <= 1'b0;
                m_wr_val    <= '0;
                m_bytesel   <= FETCH_BYTESEL;
                d_grant_ctr <= '0;
            end else if (bus_done) begin
                m_access <= 1'b0;
            end
        end
    end

    assign i_ack   = i_owner && resp_ack;
    assign i_error = i_owner && resp_err;
    assign i_data  = i_owner ? m_data : '0;
    assign d_ack   = d_owner && resp_ack;
    assign d_error = d_owner && resp_err;
    assign d_data  = d_owner ? m_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_oldland_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_oldland_bus_arbiter : directed + random stimulus against a cycle reference
// Revision 1.0
// ============================================================================
module tb_oldland_bus_arbiter;

    localparam int TIMEOUT_CYCLES = 64;
    localparam int MAX_D_GRANTS   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_access;
    logic [29:0] i_addr;
    logic        i_ack, i_error;
    logic [31:0] i_data;
    logic        d_access;
    logic [29:0] d_addr;
    logic        d_wr_en;
    logic [31:0] d_wr_val;
    logic [3:0]  d_bytesel;
    logic        d_ack, d_error;
    logic [31:0] d_data;
    logic        m_access;
    logic [29:0] m_addr;
    logic        m_wr_en;
    logic [31:0] m_wr_val;
    logic [3:0]  m_bytesel;
    logic        m_ack, m_error;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    oldland_bus_arbiter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_D_GRANTS  (MAX_D_GRANTS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_access(i_access), .i_addr(i_addr), .i_ack(i_ack), .i_error(i_error), .i_data(i_data),
        .d_access(d_access), .d_addr(d_addr), .d_wr_en(d_wr_en), .d_wr_val(d_wr_val),
        .d_bytesel(d_bytesel), .d_ack(d_ack), .d_error(d_error), .d_data(d_data),
        .m_access(m_access), .m_addr(m_addr), .m_wr_en(m_wr_en), .m_wr_val(m_wr_val),
        .m_bytesel(m_bytesel), .m_ack(m_ack), .m_error(m_error), .m_data(m_data)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: owner 0=none 1=fetch 2=data; age = busy cycle number starting at 1.
    int          owner  = 0;
    int          age    = 0;
    int          streak = 0;
    logic [29:0] f_addr;
    logic        f_wr;
    logic [31:0] f_val;
    logic [3:0]  f_bsel;
    bit          i_done, d_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called at a negedge with inputs already set; checks this cycle, advances to next negedge.
    task automatic step();
        bit busy, tmo, fin, e_ack, e_err;
        #1;
        busy = (owner != 0);
        check("m_access", 32'(m_access), 32'(busy));
        if (busy) begin
            check("m_addr", 32'(m_addr), 32'(f_addr));
            check("m_wr_en", 32'(m_wr_en), 32'(f_wr));
            check("m_bytesel", 32'(m_bytesel), 32'(f_bsel));
            if (owner == 2) check("m_wr_val", m_wr_val, f_val);
        end
        tmo   = busy && (age == TIMEOUT_CYCLES);
        fin   = busy && (m_ack || m_error || tmo);
        e_err = rst_n && busy && (m_error || (tmo && !m_ack));
        e_ack = rst_n && busy && m_ack && !m_error;
        check("i_ack", 32'(i_ack), 32'(owner == 1 && e_ack));
        check("i_error", 32'(i_error), 32'(owner == 1 && e_err));
        check("d_ack", 32'(d_ack), 32'(owner == 2 && e_ack));
        check("d_error", 32'(d_error), 32'(owner == 2 && e_err));
        if (rst_n) begin
            check("i_data", i_data, (owner == 1) ? m_data : 32'h0);
            check("d_data", d_data, (owner == 2) ? m_data : 32'h0);
        end
        i_done = rst_n && fin && owner == 1;
        d_done = rst_n && fin && owner == 2;
        if (!rst_n) begin
            owner = 0; age = 0; streak = 0;
        end else if (busy) begin
            if (fin) owner = 0;
            else     age++;
        end else if (i_access || d_access) begin
            if (d_access && !(i_access && streak == MAX_D_GRANTS)) begin
                owner  = 2;
                streak = i_access ? streak + 1 : 0;
                f_addr = d_addr; f_wr = d_wr_en; f_val = d_wr_val; f_bsel = d_bytesel;
            end else begin
                owner  = 1;
                streak = 0;
                f_addr = i_addr; f_wr = 1'b0; f_val = 32'h0; f_bsel = 4'hf;
            end
            age = 1;
        end
        @(negedge clk);
    endtask

    // Bus slave answers on busy cycle 'lat'; requesters drop when done.
    task automatic serve(input int lat, input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            m_ack   = (owner != 0 && age == lat);
            m_error = 1'b0;
            m_data  = $urandom;
            step();
            if (i_done) i_access = 1'b0;
            if (d_done) d_access = 1'b0;
            if (!i_access && !d_access && owner == 0) break;
        end
        m_ack = 1'b0;
        check("serve_budget", 32'({i_access, d_access, owner != 0}), 32'h0);
    endtask

    task automatic set_d(input logic [29:0] a, input logic w, input logic [31:0] v, input logic [3:0] b);
        d_access = 1'b1; d_addr = a; d_wr_en = w; d_wr_val = v; d_bytesel = b;
    endtask

    initial begin
        int p_resp;
        int r;
        rst_n = 1'b0; i_access = 1'b0; i_addr = '0; d_access = 1'b0; d_addr = '0;
        d_wr_en = 1'b0; d_wr_val = '0; d_bytesel = '0; m_ack = 1'b0; m_error = 1'b0; m_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_m_access", 32'(m_access), 32'h0);
        check("rst_m_addr", 32'(m_addr), 32'h0);
        check("rst_m_wr_en", 32'(m_wr_en), 32'h0);
        check("rst_m_wr_val", m_wr_val, 32'h0);
        check("rst_m_bytesel", 32'(m_bytesel), 32'h0);
        check("rst_acks", 32'({i_ack, i_error, d_ack, d_error}), 32'h0);
        @(negedge clk);

        // Single fetch, response on the 3rd busy cycle.
        i_access = 1'b1; i_addr = 30'h100;
        step();
        step(); step();
        m_ack = 1'b1; m_data = 32'hdeadbeef;
        step();
        check("fetch_done", 32'(i_done), 32'h1);
        i_access = 1'b0; m_ack = 1'b0;
        step();

        // Simultaneous request: data first, then fetch.
        i_access = 1'b1; i_addr = 30'h200;
        set_d(30'h40, 1'b1, 32'h12345678, 4'h3);
        serve(2, 20);

        // Continuous data stream while fetch waits.
        i_access = 1'b1; i_addr = 30'h300;
        set_d(30'h50, 1'b1, 32'h0, 4'h1);
        for (int c = 0; c < 40; c++) begin
            m_ack = (owner != 0 && age == 1);
            m_data = $urandom;
            step();
            if (d_done) set_d(d_addr + 30'h1, 1'b1, 32'(c), 4'h1);
            if (i_done) begin
                i_access = 1'b0;
                break;
            end
        end
        d_access = 1'b0;
        serve(1, 10);

        // Timeout of a fetch.
        i_access = 1'b1; i_addr = 30'h3ff;
        serve(1000, TIMEOUT_CYCLES + 8);

        // ack and error together on a data read, then spurious ack in idle.
        set_d(30'h60, 1'b0, 32'h0, 4'hf);
        step(); step();
        m_ack = 1'b1; m_error = 1'b1; m_data = 32'h5a5a5a5a;
        step();
        check("both_err", 32'(d_done), 32'h1);
        d_access = 1'b0; m_error = 1'b0;
        step();
        m_ack = 1'b0;
        step();

        // Reset during D_BUSY with responses around it.
        set_d(30'h70, 1'b0, 32'h0, 4'hf);
        step(); step();
        rst_n = 1'b0; m_ack = 1'b1;
        step();
        rst_n = 1'b1; d_access = 1'b0;
        step();
        m_ack = 1'b0;
        set_d(30'h71, 1'b1, 32'hcafef00d, 4'hc);
        serve(2, 10);

        // Randomised traffic with variable bus responsiveness.
        p_resp = 30;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) p_resp = ($urandom_range(0, 1) == 0) ? 30 : 2;
            if (!i_access && $urandom_range(0, 3) == 0) begin
                i_access = 1'b1; i_addr = 30'($urandom);
            end
            if (!d_access && $urandom_range(0, 3) == 0)
                set_d(30'($urandom), 1'($urandom), $urandom, 4'($urandom));
            rst_n  = ($urandom_range(0, 399) != 0);
            m_data = $urandom;
            r      = $urandom_range(0, 99);
            if (owner != 0) begin
                m_ack   = (r < p_resp) || (r == 99);
                m_error = (r >= p_resp && r < p_resp + 3) || (r == 99);
            end else begin
                m_ack   = (r < 5);
                m_error = (r >= 95);
            end
            step();
            if (!rst_n) begin
                i_access = 1'b0; d_access = 1'b0;
            end
            if (i_done) begin
                i_access = ($urandom_range(0, 1) == 0);
                i_addr   = 30'($urandom);
            end
            if (d_done) begin
                if ($urandom_range(0, 1) == 0) set_d(30'($urandom), 1'($urandom), $urandom, 4'($urandom));
                else d_access = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
